// File: rtl/lc3b_types.sv
// Shared LC-3b types.
//   lc3b_reg        : 3-bit register specifier
//   lc3b_word       : 16-bit machine word
//   lc3b_pipe_state : pipeline-control FSM state; records which memory
//                     responses are still outstanding for the current advance
package lc3b_types;

  typedef logic [2:0]  lc3b_reg;
  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    RUN       = 2'd0,  // nothing outstanding yet, requests issued fresh
    WAIT_I    = 2'd1,  // data captured (or not needed), instruction pending
    WAIT_D    = 2'd2,  // instruction captured, data pending
    WAIT_BOTH = 2'd3   // both responses pending
  } lc3b_pipe_state;

  localparam lc3b_word STALL_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/lc3b_hazard_detect.sv
// Load-use hazard compare.
// Flags a hazard when the instruction in ID/EX is a load whose destination
// matches a source register that the instruction in ID actually reads.
// Ports:
//   id_sr1, id_sr2           : ID-stage source registers
//   id_uses_sr1, id_uses_sr2 : source-valid qualifiers
//   ex_load                  : ID/EX holds a load
//   ex_dest                  : destination register of the ID/EX instruction
//   load_use                 : hazard present (combinational)
module lc3b_hazard_detect
  import lc3b_types::*;
(
  input  lc3b_reg id_sr1,
  input  lc3b_reg id_sr2,
  input  logic    id_uses_sr1,
  input  logic    id_uses_sr2,
  input  logic    ex_load,
  input  lc3b_reg ex_dest,
  output logic    load_use
);

  logic sr1_hit;
  logic sr2_hit;

  assign sr1_hit  = id_uses_sr1 && (id_sr1 == ex_dest);
  assign sr2_hit  = id_uses_sr2 && (id_sr2 == ex_dest);
  assign load_use = ex_load && (sr1_hit || sr2_hit);

endmodule

// File: rtl/lc3b_pipe_ctrl.sv
// LC-3b five-stage pipeline control.
// Sequences instruction/data memory handshakes, freezes the pipeline until
// every response for the current step is available (live or in a hold
// register), inserts a single bubble on load-use hazards and flushes the
// younger stages on a taken branch.
// Optional feature: define LC3B_PIPE_PERF_EN to add the stall_count port and
// its saturating counter.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   if_mem_resp, dmem_resp           : memory responses
//   mem_read, mem_write              : MEM stage data access request
//   id_sr1/2, id_uses_sr1/2          : ID sources
//   ex_load, ex_dest                 : ID/EX load info
//   br_taken                         : taken branch resolved in MEM
//   pc_load .. mem_wb_load           : pipeline register enables
//   if_id_flush, id_ex_bubble,
//   ex_mem_flush                     : squash controls
//   imem_read, dmem_read, dmem_write : memory requests
//   ir_hold_load, dr_hold_load       : capture early response into hold reg
//   use_hold                         : advance consumes a hold register
//   stall_count                      : stall cycles (LC3B_PIPE_PERF_EN only)
module lc3b_pipe_ctrl
  import lc3b_types::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    if_mem_resp,
  input  logic    mem_read,
  input  logic    mem_write,
  input  logic    dmem_resp,
  input  lc3b_reg id_sr1,
  input  lc3b_reg id_sr2,
  input  logic    id_uses_sr1,
  input  logic    id_uses_sr2,
  input  logic    ex_load,
  input  lc3b_reg ex_dest,
  input  logic    br_taken,
  output logic    pc_load,
  output logic    if_id_load,
  output logic    id_ex_load,
  output logic    ex_mem_load,
  output logic    mem_wb_load,
  output logic    if_id_flush,
  output logic    id_ex_bubble,
  output logic    ex_mem_flush,
  output logic    imem_read,
  output logic    dmem_read,
  output logic    dmem_write,
  output logic    ir_hold_load,
  output logic    dr_hold_load,
  output logic    use_hold
`ifdef LC3B_PIPE_PERF_EN
  ,
  output lc3b_word stall_count
`endif
);

  lc3b_pipe_state state_reg;
  lc3b_pipe_state state_next;

  logic dacc;       // MEM stage needs the data port this step
  logic d_done;     // data side satisfied by a live response (or not needed)
  logic advance;
  logic ir_hold;
  logic dr_hold;
  logic hold_used;
  logic imem_req;
  logic dmem_rd;
  logic dmem_wr;
  logic load_use;
  logic lu_stall;

  assign dacc   = mem_read || mem_write;
  assign d_done = !dacc || dmem_resp;

  lc3b_hazard_detect u_hazard (
    .id_sr1      (id_sr1),
    .id_sr2      (id_sr2),
    .id_uses_sr1 (id_uses_sr1),
    .id_uses_sr2 (id_uses_sr2),
    .ex_load     (ex_load),
    .ex_dest     (ex_dest),
    .load_use    (load_use)
  );

  // Next-state and handshake decode. Responses must steer the pipeline in
  // the cycle they arrive, so this is a Mealy decode on the current state.
  always_comb begin
    state_next = state_reg;
    advance    = 1'b0;
    ir_hold    = 1'b0;
    dr_hold    = 1'b0;
    hold_used  = 1'b0;
    imem_req   = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    case (state_reg)
      RUN: begin
        imem_req = 1'b1;
        dmem_rd  = mem_read;
        dmem_wr  = mem_write;
        if (if_mem_resp && d_done) begin
          advance = 1'b1;
        end else if (if_mem_resp) begin
          ir_hold    = 1'b1;
          state_next = WAIT_D;
        end else if (d_done) begin
          // Without a data access there is nothing to capture; only the
          // instruction is still owed.
          dr_hold    = dacc;
          state_next = WAIT_I;
        end else begin
          state_next = WAIT_BOTH;
        end
      end
      WAIT_I: begin
        imem_req = 1'b1;
        if (if_mem_resp) begin
          advance    = 1'b1;
          hold_used  = dacc;  // frozen MEM stage: dacc implies data was held
          state_next = RUN;
        end
      end
      WAIT_D: begin
        dmem_rd = mem_read;
        dmem_wr = mem_write;
        if (dmem_resp) begin
          advance    = 1'b1;
          hold_used  = 1'b1;
          state_next = RUN;
        end
      end
      WAIT_BOTH: begin
        imem_req = 1'b1;
        dmem_rd  = mem_read;
        dmem_wr  = mem_write;
        if (if_mem_resp && dmem_resp) begin
          advance    = 1'b1;
          state_next = RUN;
        end else if (if_mem_resp) begin
          ir_hold    = 1'b1;
          state_next = WAIT_D;
        end else if (dmem_resp) begin
          dr_hold    = 1'b1;
          state_next = WAIT_I;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // A taken branch squashes the instruction that would stall, so the
  // branch wins over load-use.
  assign lu_stall = advance && load_use && !br_taken;

  always_comb begin
    pc_load      = 1'b0;
    if_id_load   = 1'b0;
    id_ex_load   = 1'b0;
    ex_mem_load  = 1'b0;
    mem_wb_load  = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_bubble = 1'b1;
    ex_mem_flush = 1'b1;
    imem_read    = 1'b0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    ir_hold_load = 1'b0;
    dr_hold_load = 1'b0;
    use_hold     = 1'b0;
    if (rst_n) begin
      pc_load      = advance && !lu_stall;
      if_id_load   = advance && !lu_stall;
      id_ex_load   = advance;
      ex_mem_load  = advance;
      mem_wb_load  = advance;
      if_id_flush  = advance && br_taken;
      id_ex_bubble = advance && (br_taken || load_use);
      ex_mem_flush = advance && br_taken;
      imem_read    = imem_req;
      dmem_read    = dmem_rd;
      dmem_write   = dmem_wr;
      ir_hold_load = ir_hold;
      dr_hold_load = dr_hold;
      use_hold     = advance && hold_used;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef LC3B_PIPE_PERF_EN
  lc3b_word stall_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_reg <= '0;
    end else if ((!advance || lu_stall) && (stall_count_reg != STALL_COUNT_MAX)) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_lc3b_pipe_ctrl.sv
// Testbench for lc3b_pipe_ctrl: directed scenarios plus constrained-random
// traffic checked against a model that tracks which responses have been
// captured for the current pipeline step.
module tb_lc3b_pipe_ctrl;
  import lc3b_types::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    if_mem_resp = 1'b0, mem_read = 1'b0, mem_write = 1'b0, dmem_resp = 1'b0;
  lc3b_reg id_sr1 = '0, id_sr2 = '0, ex_dest = '0;
  logic    id_uses_sr1 = 1'b0, id_uses_sr2 = 1'b0, ex_load = 1'b0, br_taken = 1'b0;
  logic    pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic    if_id_flush, id_ex_bubble, ex_mem_flush;
  logic    imem_read, dmem_read, dmem_write, ir_hold_load, dr_hold_load, use_hold;
`ifdef LC3B_PIPE_PERF_EN
  lc3b_word stall_count;
`endif

  always #5 clk = ~clk;

  lc3b_pipe_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_mem_resp  (if_mem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .dmem_resp    (dmem_resp),
    .id_sr1       (id_sr1),
    .id_sr2       (id_sr2),
    .id_uses_sr1  (id_uses_sr1),
    .id_uses_sr2  (id_uses_sr2),
    .ex_load      (ex_load),
    .ex_dest      (ex_dest),
    .br_taken     (br_taken),
    .pc_load      (pc_load),
    .if_id_load   (if_id_load),
    .id_ex_load   (id_ex_load),
    .ex_mem_load  (ex_mem_load),
    .mem_wb_load  (mem_wb_load),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_mem_flush (ex_mem_flush),
    .imem_read    (imem_read),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .ir_hold_load (ir_hold_load),
    .dr_hold_load (dr_hold_load),
    .use_hold     (use_hold)
`ifdef LC3B_PIPE_PERF_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Model: what has already been captured for the step in progress.
  bit m_i_have = 1'b0;
  bit m_d_have = 1'b0;
  int m_stalls = 0;
  bit last_adv = 1'b1;
  logic [13:0] last_out;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_load_use();
    return ex_load && ((id_uses_sr1 && id_sr1 == ex_dest) || (id_uses_sr2 && id_sr2 == ex_dest));
  endfunction

  // Bit order: 13 pc,12 if_id,11 id_ex,10 ex_mem,9 mem_wb,8 if_id_flush,
  // 7 id_ex_bubble,6 ex_mem_flush,5 imem,4 dread,3 dwrite,2 ir_hold,
  // 1 dr_hold,0 use_hold
  function automatic logic [13:0] model_out();
    bit dacc, need_d, i_ok, d_ok, adv, lu, br, keep_front;
    if (!rst_n) return 14'b00000_111_000_000;
    dacc   = mem_read || mem_write;
    need_d = dacc && !m_d_have;
    i_ok   = m_i_have || if_mem_resp;
    d_ok   = !dacc || m_d_have || dmem_resp;
    adv    = i_ok && d_ok;
    lu     = m_load_use();
    br     = br_taken;
    keep_front = adv && (br || !lu);
    return {keep_front, keep_front, adv, adv, adv,
            adv && br, adv && (br || lu), adv && br,
            !m_i_have, need_d && mem_read, need_d && mem_write,
            !m_i_have && if_mem_resp && !adv, need_d && dmem_resp && !adv,
            adv && (m_i_have || m_d_have)};
  endfunction

  // Entered just after a negedge with inputs settled; leaves at the next negedge.
  task automatic tick(input string tag);
    logic [13:0] exp;
    bit adv_now, lu_stall, need_d;
    #2;
    last_out = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                if_id_flush, id_ex_bubble, ex_mem_flush,
                imem_read, dmem_read, dmem_write, ir_hold_load, dr_hold_load, use_hold};
    exp = model_out();
    check_eq(tag, 32'(last_out), 32'(exp));
`ifdef LC3B_PIPE_PERF_EN
    check_eq({tag, "_stalls"}, 32'(stall_count), 32'(m_stalls));
`endif
    adv_now  = exp[11];
    lu_stall = exp[7] && !exp[8];
    need_d   = (mem_read || mem_write) && !m_d_have;
    @(posedge clk);
    if (!rst_n) begin
      m_i_have = 1'b0;
      m_d_have = 1'b0;
      m_stalls = 0;
      last_adv = 1'b1;
    end else begin
      if (adv_now) begin
        m_i_have = 1'b0;
        m_d_have = 1'b0;
      end else begin
        m_i_have = m_i_have || if_mem_resp;
        m_d_have = m_d_have || (need_d && dmem_resp);
      end
      if ((!adv_now || lu_stall) && m_stalls < 65535) m_stalls++;
      last_adv = adv_now;
    end
    @(negedge clk);
  endtask

  task automatic set_ops(input logic rd, input logic wr, input logic br, input logic ld);
    mem_read = rd; mem_write = wr; br_taken = br; ex_load = ld;
  endtask

  initial begin
    int bubbles, pc_holds;
    @(negedge clk);
    // Reset state
    tick("reset0");
    tick("reset1");
    rst_n = 1'b1;

    // Instruction response every cycle, no data access
    set_ops(0, 0, 0, 0);
    if_mem_resp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("stream");
      check_eq("stream_adv", 32'(last_out[13]), 32'd1);
    end

    // Data read: instruction at cycle 0, data at cycle 3
    set_ops(1, 0, 0, 0);
    if_mem_resp = 1'b1; dmem_resp = 1'b0;
    tick("ld_c0");
    check_eq("ld_irhold", 32'(last_out[2]), 32'd1);
    if_mem_resp = 1'b0;
    for (int i = 1; i < 3; i++) begin
      tick("ld_wait");
      check_eq("ld_wait_req", 32'(last_out[5:4]), 32'b01);
    end
    dmem_resp = 1'b1;
    tick("ld_c3");
    check_eq("ld_adv_hold", 32'({last_out[13], last_out[0]}), 32'b11);
    dmem_resp = 1'b0;

    // Load-use: one bubble, then the bubble sits in EX
    set_ops(0, 0, 0, 1);
    ex_dest = 3'd2; id_sr1 = 3'd2; id_uses_sr1 = 1'b1; id_uses_sr2 = 1'b0;
    if_mem_resp = 1'b1;
    bubbles = 0; pc_holds = 0;
    for (int i = 0; i < 3; i++) begin
      tick("lu");
      bubbles  += int'(last_out[7]);
      pc_holds += int'(!last_out[13]);
      ex_load = 1'b0;
    end
    check_eq("lu_bubbles", 32'(bubbles), 32'd1);
    check_eq("lu_pc_holds", 32'(pc_holds), 32'd1);
    id_uses_sr1 = 1'b0;

    // Branch held across WAIT_I
    set_ops(1, 0, 1, 0);
    if_mem_resp = 1'b0; dmem_resp = 1'b1;
    tick("br_run");
    check_eq("br_drhold", 32'(last_out[1]), 32'd1);
    dmem_resp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick("br_wait");
      check_eq("br_noflush", 32'(last_out[8:6]), 32'b000);
    end
    if_mem_resp = 1'b1;
    tick("br_adv");
    check_eq("br_flush", 32'({last_out[13], last_out[8:6]}), 32'b1111);
    set_ops(0, 0, 0, 0);

    // Reset during WAIT_BOTH
    set_ops(1, 0, 0, 0);
    if_mem_resp = 1'b0; dmem_resp = 1'b0;
    tick("wb_enter");
    tick("wb_hold");
    check_eq("wb_reqs", 32'(last_out[5:4]), 32'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_reqs", 32'({imem_read, dmem_read, dmem_write}), 32'b000);
    m_i_have = 1'b0; m_d_have = 1'b0; m_stalls = 0;
    @(negedge clk);
    tick("rst_mid");
`ifdef LC3B_PIPE_PERF_EN
    check_eq("rst_stall", 32'(stall_count), 32'd0);
`endif
    rst_n = 1'b1;
    set_ops(0, 0, 0, 0);
    if_mem_resp = 1'b1;
    tick("post_rst");
    check_eq("post_rst_run", 32'({last_out[13], last_out[5]}), 32'b11);

    // Random traffic; pipeline-side inputs only change after an advance.
    for (int n = 0; n < 600; n++) begin
      if (last_adv) begin
        case ($urandom_range(0, 2))
          0: begin mem_read = 1'b0; mem_write = 1'b0; end
          1: begin mem_read = 1'b1; mem_write = 1'b0; end
          default: begin mem_read = 1'b0; mem_write = 1'b1; end
        endcase
        br_taken    = ($urandom_range(0, 5) == 0);
        ex_load     = $urandom_range(0, 1) == 1;
        ex_dest     = lc3b_reg'($urandom_range(0, 7));
        id_sr1      = lc3b_reg'($urandom_range(0, 7));
        id_sr2      = lc3b_reg'($urandom_range(0, 7));
        id_uses_sr1 = $urandom_range(0, 1) == 1;
        id_uses_sr2 = $urandom_range(0, 1) == 1;
      end
      if_mem_resp = $urandom_range(0, 2) != 0;
      dmem_resp   = $urandom_range(0, 2) != 0;
      rst_n       = $urandom_range(0, 63) != 0;
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
